// File: rtl/lcd_bus_driver.sv
// lcd_bus_driver
// Converts the memory-mapped LCD byte taps (data, control, enable) into
// HD44780-style parallel write cycles: setup, E pulse, hold, then an
// execution wait. All timing is counted in clk cycles. A one-deep pending
// slot holds a trigger that arrives while a write is in progress.
//
// Optional feature macro: LCD_LONG_CMD_EN
//   defined   -> clear (8'h01) and home (8'h02/8'h03) commands wait LONG_CYCLES
//   undefined -> every write waits EXEC_CYCLES
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   lcd_data    byte to write
//   lcd_ctrl    bit0 = RS (1 data, 0 command), bit1 = backlight
//   lcd_enable  trigger; a 0->1 transition starts a write
//   lcd_d       LCD data bus
//   lcd_rs      register select
//   lcd_rw      tied 0 (write-only)
//   lcd_e       LCD enable strobe, high only during the pulse phase
//   lcd_bl      backlight, latched with each accepted write
//   busy        high whenever the driver is not idle
//   overrun     sticky; set when a trigger had to be dropped
module lcd_bus_driver #(
    parameter int unsigned SETUP_CYCLES = 2,
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES  = 2,
    parameter int unsigned EXEC_CYCLES  = 40,
    parameter int unsigned LONG_CYCLES  = 1600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] lcd_data,
    input  logic [1:0] lcd_ctrl,
    input  logic       lcd_enable,
    output logic [7:0] lcd_d,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       lcd_bl,
    output logic       busy,
    output logic       overrun
);

    localparam int unsigned CNT_W = 16;

    // Counters are loaded with (count - 1) and the phase ends when they reach 0.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             en_q;
    logic [7:0]       d_q;
    logic             rs_q;
    logic             bl_q;
    logic             e_q;
    logic             busy_q;
    logic             ovr_q;
    logic             pend_q;
    logic [7:0]       pend_data_q;
    logic             pend_rs_q;
    logic             pend_bl_q;

    logic             trig_c;
    logic             long_cmd_c;
    logic             cnt_zero_c;
    logic [CNT_W-1:0] wait_ld_c;

    assign trig_c     = lcd_enable & ~en_q;
    assign cnt_zero_c = (cnt_q == '0);

    // Long execution wait applies to clear/home commands of the write in flight.
`ifdef LCD_LONG_CMD_EN
    assign long_cmd_c = ~rs_q && (d_q[7:2] == 6'd0) && (d_q[1:0] != 2'd0);
`else
    assign long_cmd_c = 1'b0;
`endif

    assign wait_ld_c = long_cmd_c ? LONG_LD : EXEC_LD;

    // Write-cycle sequencer, pending slot and registered pin drivers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            en_q        <= 1'b1;
            d_q         <= 8'h00;
            rs_q        <= 1'b0;
            bl_q        <= 1'b0;
            e_q         <= 1'b0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
            pend_q      <= 1'b0;
            pend_data_q <= 8'h00;
            pend_rs_q   <= 1'b0;
            pend_bl_q   <= 1'b0;
        end else begin
            en_q <= lcd_enable;

            // Trigger during an active write goes to the pending slot, or is
            // dropped when the slot is full. A WAIT exit that consumes the
            // slot clears pend_q below, overriding this capture path.
            if (trig_c && (state_q != S_IDLE)) begin
                if (pend_q) begin
                    ovr_q <= 1'b1;
                end else begin
                    pend_q      <= 1'b1;
                    pend_data_q <= lcd_data;
                    pend_rs_q   <= lcd_ctrl[0];
                    pend_bl_q   <= lcd_ctrl[1];
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (pend_q) begin
                        // Slot filled on the final WAIT cycle: start it now.
                        state_q <= S_SETUP;
                        cnt_q   <= SETUP_LD;
                        busy_q  <= 1'b1;
                        d_q     <= pend_data_q;
                        rs_q    <= pend_rs_q;
                        bl_q    <= pend_bl_q;
                        pend_q  <= trig_c;
                        if (trig_c) begin
                            pend_data_q <= lcd_data;
                            pend_rs_q   <= lcd_ctrl[0];
                            pend_bl_q   <= lcd_ctrl[1];
                        end
                    end else if (trig_c) begin
                        state_q <= S_SETUP;
                        cnt_q   <= SETUP_LD;
                        busy_q  <= 1'b1;
                        d_q     <= lcd_data;
                        rs_q    <= lcd_ctrl[0];
                        bl_q    <= lcd_ctrl[1];
                    end
                end
                S_SETUP: begin
                    if (cnt_zero_c) begin
                        state_q <= S_PULSE;
                        cnt_q   <= PULSE_LD;
                        e_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_PULSE: begin
                    if (cnt_zero_c) begin
                        state_q <= S_HOLD;
                        cnt_q   <= HOLD_LD;
                        e_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt_zero_c) begin
                        state_q <= S_WAIT;
                        cnt_q   <= wait_ld_c;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (cnt_zero_c) begin
                        if (pend_q) begin
                            // Back-to-back: no idle cycle between writes.
                            state_q <= S_SETUP;
                            cnt_q   <= SETUP_LD;
                            d_q     <= pend_data_q;
                            rs_q    <= pend_rs_q;
                            bl_q    <= pend_bl_q;
                            pend_q  <= 1'b0;
                        end else begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    e_q     <= 1'b0;
                end
            endcase
        end
    end

    assign lcd_d   = d_q;
    assign lcd_rs  = rs_q;
    assign lcd_rw  = 1'b0;
    assign lcd_e   = e_q;
    assign lcd_bl  = bl_q;
    assign busy    = busy_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// tb_lcd_bus_driver
// Directed bench for lcd_bus_driver with default timing parameters.
// Inputs change 1 time unit after the rising edge; outputs are checked at
// the same point, after the edge has settled.
module tb_lcd_bus_driver;

    localparam int unsigned S = 2;
    localparam int unsigned P = 4;
    localparam int unsigned H = 2;
    localparam int unsigned X = 40;
`ifdef LCD_LONG_CMD_EN
    localparam int unsigned X_CMD = 1600;
`else
    localparam int unsigned X_CMD = 40;
`endif
    localparam int unsigned B = S + P + H + X;

    logic       clk;
    logic       rst;
    logic [7:0] lcd_data;
    logic [1:0] lcd_ctrl;
    logic       lcd_enable;
    logic [7:0] lcd_d;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic       lcd_bl;
    logic       busy;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;

    lcd_bus_driver dut (
        .clk       (clk),
        .rst       (rst),
        .lcd_data  (lcd_data),
        .lcd_ctrl  (lcd_ctrl),
        .lcd_enable(lcd_enable),
        .lcd_d     (lcd_d),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .lcd_bl    (lcd_bl),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;

        // Reset with enable already high
        rst        = 1'b1;
        lcd_data   = 8'h00;
        lcd_ctrl   = 2'b00;
        lcd_enable = 1'b1;
        #1;
        check("rst_d", 32'(lcd_d), 32'h00);
        check("rst_rs", 32'(lcd_rs), 32'h0);
        check("rst_rw", 32'(lcd_rw), 32'h0);
        check("rst_e", 32'(lcd_e), 32'h0);
        check("rst_bl", 32'(lcd_bl), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        step();
        step();
        rst = 1'b0;

        // Level held high across reset release must not start a write
        for (int k = 0; k < 10; k++) begin
            step();
            check("hold_hi_busy", 32'(busy), 32'h0);
            check("hold_hi_e", 32'(lcd_e), 32'h0);
        end
        lcd_enable = 1'b0;
        step();
        check("low_busy", 32'(busy), 32'h0);

        // Single data write 8'h41, RS=1, BL=1
        lcd_data   = 8'h41;
        lcd_ctrl   = 2'b11;
        lcd_enable = 1'b1;
        step();
        lcd_enable = 1'b0;
        check("w1_d", 32'(lcd_d), 32'h41);
        check("w1_rs", 32'(lcd_rs), 32'h1);
        check("w1_bl", 32'(lcd_bl), 32'h1);
        check("w1_busy0", 32'(busy), 32'h1);
        check("w1_e0", 32'(lcd_e), 32'h0);
        for (int k = 1; k <= 52; k++) begin
            step();
            check("w1_e", 32'(lcd_e), 32'((k >= S) && (k < S + P)));
            check("w1_busy", 32'(busy), 32'(k < B));
        end
        check("w1_d_idle", 32'(lcd_d), 32'h41);

        // Two triggers 10 cycles apart: back-to-back writes, no overrun
        lcd_data   = 8'h30;
        lcd_ctrl   = 2'b01;
        lcd_enable = 1'b1;
        step();
        lcd_enable = 1'b0;
        check("w2_d0", 32'(lcd_d), 32'h30);
        check("w2_bl0", 32'(lcd_bl), 32'h0);
        for (int k = 1; k <= 100; k++) begin
            step();
            check("w2_e", 32'(lcd_e),
                  32'(((k >= S) && (k < S + P)) || ((k >= B + S) && (k < B + S + P))));
            check("w2_busy", 32'(busy), 32'(k < 2 * B));
            check("w2_d", 32'(lcd_d), (k < B) ? 32'h30 : 32'h31);
            check("w2_ovr", 32'(overrun), 32'h0);
            if (k == 10) begin
                lcd_data   = 8'h31;
                lcd_enable = 1'b1;
            end
            if (k == 11) lcd_enable = 1'b0;
        end

        // Three triggers in one busy window: second performed, third dropped
        lcd_data   = 8'h50;
        lcd_ctrl   = 2'b01;
        lcd_enable = 1'b1;
        step();
        lcd_enable = 1'b0;
        check("w3_d0", 32'(lcd_d), 32'h50);
        for (int k = 1; k <= 110; k++) begin
            step();
            check("w3_ovr", 32'(overrun), 32'(k >= 11));
            check("w3_busy", 32'(busy), 32'(k < 2 * B));
            check("w3_d", 32'(lcd_d), (k < B) ? 32'h50 : 32'h51);
            if (k == 5) begin
                lcd_data   = 8'h51;
                lcd_enable = 1'b1;
            end
            if (k == 6) lcd_enable = 1'b0;
            if (k == 10) begin
                lcd_data   = 8'h52;
                lcd_enable = 1'b1;
            end
            if (k == 11) lcd_enable = 1'b0;
        end

        // Only reset clears the sticky overrun
        rst = 1'b1;
        #1;
        check("ovr_clr", 32'(overrun), 32'h0);
        check("ovr_clr_d", 32'(lcd_d), 32'h00);
        step();
        rst = 1'b0;
        step();
        step();

        // Clear-display command: execution wait depends on the build option
        lcd_data   = 8'h01;
        lcd_ctrl   = 2'b00;
        lcd_enable = 1'b1;
        step();
        lcd_enable = 1'b0;
        check("cmd_d", 32'(lcd_d), 32'h01);
        check("cmd_rs", 32'(lcd_rs), 32'h0);
        n = 0;
        for (int k = 0; (k < 2000) && (busy === 1'b1); k++) begin
            n++;
            step();
        end
        check("cmd_busy_len", 32'(n), 32'(S + P + H + X_CMD));

        // Reset during the E pulse with a write pending
        step();
        lcd_data   = 8'h77;
        lcd_ctrl   = 2'b11;
        lcd_enable = 1'b1;
        step();
        lcd_enable = 1'b0;
        step();
        lcd_data   = 8'h66;
        lcd_enable = 1'b1;
        step();
        step();
        check("rp_e_before", 32'(lcd_e), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("rp_e", 32'(lcd_e), 32'h0);
        check("rp_busy", 32'(busy), 32'h0);
        check("rp_d", 32'(lcd_d), 32'h00);
        check("rp_rs", 32'(lcd_rs), 32'h0);
        check("rp_bl", 32'(lcd_bl), 32'h0);
        check("rp_ovr", 32'(overrun), 32'h0);
        #3;
        rst = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step();
            check("rp_idle_busy", 32'(busy), 32'h0);
            check("rp_idle_e", 32'(lcd_e), 32'h0);
        end
        check("rp_idle_d", 32'(lcd_d), 32'h00);

        // Lower then raise after reset: exactly one write starts
        lcd_enable = 1'b0;
        step();
        lcd_data   = 8'h12;
        lcd_ctrl   = 2'b01;
        lcd_enable = 1'b1;
        step();
        check("post_busy", 32'(busy), 32'h1);
        check("post_d", 32'(lcd_d), 32'h12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
